// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scan driver for a common-anode 7-segment display.
// Shows one BCD digit per slot, with a blanking gap at the start of each slot.
// New values are double-buffered and only take effect at a frame boundary.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   load       : one-cycle strobe, captures value_bcd into the pending buffer
//   value_bcd  : packed BCD value, nibble i = digit i (digit 0 = least significant)
//   lzb_en     : leading-zero blanking enable, sampled on entry to each slot's ON phase
//   bcd        : registered BCD digit for the current slot, to the decoder
//   dig_n      : registered active-low digit enables
//   frame_done : one-cycle pulse at the start of each new frame
module seg_scan_mux #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_bcd,
    input  logic                  lzb_en,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * DIGITS;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VAL_W-1:0]    active_q, active_d;
    logic [VAL_W-1:0]    pending_q, pending_d;
    logic                pend_valid_q, pend_valid_d;
    logic                lzb_q, lzb_d;
    logic [3:0]          bcd_q, bcd_d;
    logic [DIGITS-1:0]   dig_n_q, dig_n_d;
    logic                frame_done_q, frame_done_d;

    logic                wrap;
    logic                frame_edge;
    logic                on_entry;
    logic                zero_run;
    logic [DIGITS-1:0]   lz_mask;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            lzb_q        <= 1'b0;
            bcd_q        <= 4'h0;
            dig_n_q      <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            lzb_q        <= lzb_d;
            bcd_q        <= bcd_d;
            dig_n_q      <= dig_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state and next-output logic; outputs are computed from the
    // next-cycle slot position so that the registered outputs line up with cnt.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        active_d     = active_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        lzb_d        = lzb_q;
        bcd_d        = bcd_q;
        dig_n_d      = '1;
        zero_run     = 1'b1;
        lz_mask      = '0;

        wrap       = (cnt_q == CNT_W'(SCAN_DIV - 1));
        frame_edge = wrap && (idx_q == IDX_W'(DIGITS - 1));

        if (wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        // Commit uses the old pending contents; a same-edge load stays pending.
        if (frame_edge && pend_valid_q) begin
            active_d     = pending_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pending_d    = value_bcd;
            pend_valid_d = 1'b1;
        end

        case (state_q)
            BLANK: if (cnt_d >= CNT_W'(BLANK_CYCLES)) state_d = ON;
            ON:    if (wrap && (BLANK_CYCLES != 0)) state_d = BLANK;
            default: state_d = BLANK;
        endcase

        on_entry = (cnt_d == CNT_W'(BLANK_CYCLES));
        if (on_entry) lzb_d = lzb_en;

        // lz_mask[i] set when nibbles DIGITS-1 down to i are all zero
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_run   = zero_run && (active_d[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end

        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_d == IDX_W'(i)) begin
                if (wrap) bcd_d = active_d[4*i +: 4];
                if ((state_d == ON) && !(lzb_d && lz_mask[i])) dig_n_d[i] = 1'b0;
            end
        end

        frame_done_d = frame_edge;
    end

    assign bcd        = bcd_q;
    assign dig_n      = dig_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux with DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
// Cycle c is the interval whose closing rising edge is edge c (edge 0 is the
// first edge after reset release); outputs are sampled on the falling edge.
module tb_seg_scan_mux;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value_bcd;
    logic        lzb_en;
    logic [3:0]  bcd;
    logic [3:0]  dig_n;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Reference model state: cycle index, active/pending buffers, sampled lzb
    int          m_t = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_pend = '0;
    logic        m_pv = 1'b0;
    logic        m_lzb = 1'b0;

    seg_scan_mux #(
        .DIGITS(4),
        .SCAN_DIV(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .value_bcd(value_bcd),
        .lzb_en(lzb_en),
        .bcd(bcd),
        .dig_n(dig_n),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, m_t, act, exp);
        end
    endtask

    // Model update: the frame commit happens on the last edge of each 32-cycle
    // frame, and lzb_en is taken on the edge just before the ON phase.
    always @(posedge clk) begin
        if (rst) begin
            m_t      <= 0;
            m_active <= '0;
            m_pend   <= '0;
            m_pv     <= 1'b0;
            m_lzb    <= 1'b0;
        end else begin
            if ((m_t % 32 == 31) && m_pv) begin
                m_active <= m_pend;
                m_pv     <= 1'b0;
            end
            if (load) begin
                m_pend <= value_bcd;
                m_pv   <= 1'b1;
            end
            if (m_t % 8 == 1) m_lzb <= lzb_en;
            m_t <= m_t + 1;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        int          pos;
        int          dg;
        logic [15:0] sh;
        logic        blanked;
        logic [3:0]  exp_dig;
        logic [3:0]  exp_bcd;
        logic        exp_fd;
        if (rst) begin
            exp_dig = 4'hF;
            exp_bcd = 4'h0;
            exp_fd  = 1'b0;
        end else begin
            pos     = m_t % 8;
            dg      = (m_t / 8) % 4;
            sh      = m_active >> (4 * dg);
            exp_bcd = sh[3:0];
            blanked = m_lzb && (dg >= 1) && (sh == 16'h0);
            exp_dig = 4'hF;
            if ((pos >= 2) && !blanked) exp_dig[dg] = 1'b0;
            exp_fd  = (m_t != 0) && (m_t % 32 == 0);
        end
        chk("model_dig_n", {12'h0, dig_n}, {12'h0, exp_dig});
        chk("model_bcd", {12'h0, bcd}, {12'h0, exp_bcd});
        chk("model_frame_done", {15'h0, frame_done}, {15'h0, exp_fd});
    end

    task automatic run_to(input int c);
        int n = 0;
        while (m_t != c) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                errors++;
                $display("FAIL run_to_timeout cycle=%0d actual=%0d required=%0d", m_t, m_t, c);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic pulse(input int c, input logic [15:0] v);
        run_to(c);
        load      = 1'b1;
        value_bcd = v;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic lit(input string name, input int c, input logic [3:0] act_exp_dig,
                       input logic [3:0] exp_bcd);
        run_to(c);
        chk({name, "_dig_n"}, {12'h0, dig_n}, {12'h0, act_exp_dig});
        chk({name, "_bcd"}, {12'h0, bcd}, {12'h0, exp_bcd});
    endtask

    initial begin
        rst       = 1'b0;
        load      = 1'b0;
        value_bcd = 16'h0;
        lzb_en    = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dig_n", {12'h0, dig_n}, 16'h000F);
        chk("reset_bcd", {12'h0, bcd}, 16'h0000);
        chk("reset_fd", {15'h0, frame_done}, 16'h0000);
        rst = 1'b0;

        // Scan timing and double buffer
        lit("scan_c1", 1, 4'b1111, 4'h0);
        lit("scan_c2", 2, 4'b1110, 4'h0);
        pulse(3, 16'h1234);
        lit("scan_c10", 10, 4'b1101, 4'h0);
        lit("scan_c23", 23, 4'b1011, 4'h0);
        lit("buf_c31", 31, 4'b0111, 4'h0);
        run_to(32);
        chk("fd_c32", {15'h0, frame_done}, 16'h0001);
        chk("buf_c32_bcd", {12'h0, bcd}, 16'h0004);
        run_to(33);
        chk("fd_c33", {15'h0, frame_done}, 16'h0000);
        lit("buf_c40", 40, 4'b1111, 4'h3);

        // Load race: last load wins; boundary-edge load defers a frame
        pulse(42, 16'h1111);
        lit("buf_c50", 50, 4'b1011, 4'h2);
        pulse(52, 16'h2222);
        lit("buf_c58", 58, 4'b0111, 4'h1);
        lit("race_c64", 64, 4'b1111, 4'h2);
        pulse(70, 16'h5555);
        pulse(95, 16'h3333);
        lit("race_c96", 96, 4'b1111, 4'h5);
        lit("race_c128", 128, 4'b1111, 4'h3);

        // Leading-zero blanking
        lzb_en = 1'b1;
        pulse(130, 16'h0070);
        lit("lzb_c162", 162, 4'b1110, 4'h0);
        lit("lzb_c170", 170, 4'b1101, 4'h7);
        lit("lzb_c178", 178, 4'b1111, 4'h0);
        lit("lzb_c186", 186, 4'b1111, 4'h0);
        pulse(190, 16'h0000);
        lit("lzb0_c194", 194, 4'b1110, 4'h0);
        lit("lzb0_c202", 202, 4'b1111, 4'h0);
        run_to(224);
        lzb_en = 1'b0;
        lit("nolzb_c226", 226, 4'b1110, 4'h0);
        pulse(230, 16'hF0A9);
        lit("nolzb_c242", 242, 4'b1011, 4'h0);
        lit("nolzb_c250", 250, 4'b0111, 4'h0);

        // Out-of-range nibbles pass through
        lit("inv_c258", 258, 4'b1110, 4'h9);
        lit("inv_c266", 266, 4'b1101, 4'hA);
        lit("inv_c274", 274, 4'b1011, 4'h0);
        lit("inv_c282", 282, 4'b0111, 4'hF);

        // Async reset mid-ON drops pending and restarts the scan
        pulse(290, 16'h1234);
        lit("prerst_c300", 300, 4'b1101, 4'hA);
        #2 rst = 1'b1;
        #1;
        chk("async_dig_n", {12'h0, dig_n}, 16'h000F);
        chk("async_bcd", {12'h0, bcd}, 16'h0000);
        chk("async_fd", {15'h0, frame_done}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lit("post_c2", 2, 4'b1110, 4'h0);
        run_to(32);
        chk("post_fd_c32", {15'h0, frame_done}, 16'h0001);
        chk("post_bcd_c32", {12'h0, bcd}, 16'h0000);
        lit("post_c42", 42, 4'b1101, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
